// File: rtl/sign_text_stabilizer.sv
// Turns per-frame finger status into a debounced stream of sign codes.
// A candidate must repeat on STABLE_FRAMES hand frames before it is queued once in a FWFT FIFO.
module sign_text_stabilizer #(
    parameter int NUM_FINGERS   = 5,
    parameter int SIGN_W        = 4,
    parameter int STABLE_FRAMES = 3,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_end,
    input  logic [NUM_FINGERS-1:0]          finger_status,
    input  logic                            hand_present,
    input  logic                            mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W-1:0]               out_sign,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [SIGN_W-1:0]               cur_sign,
    output logic                            locked,
    output logic                            overflow,
    input  logic                            overflow_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SIGN_W-1:0]   cur_sign_q, cur_sign_d;
    logic [SIGN_W-1:0]   pop_cnt;
    logic [SIGN_W-1:0]   candidate;
    logic                push;

    logic [SIGN_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                full;
    logic                pop;
    logic                push_accept;
    logic                drop;

    // Candidate code for this frame
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_FINGERS; i++) begin
            pop_cnt = pop_cnt + SIGN_W'(finger_status[i]);
        end
        candidate = mode ? finger_status[SIGN_W-1:0] : pop_cnt;
    end

    // Stabilizer FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_sign_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sign_q <= cur_sign_d;
        end
    end

    // Stabilizer FSM: next state; everything holds unless a frame ends
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sign_d = cur_sign_q;
        push       = 1'b0;
        if (frame_end) begin
            if (!hand_present) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (state_q == IDLE || candidate != cur_sign_q) begin
                cnt_d      = 4'd1;
                cur_sign_d = candidate;
                if (STABLE_CNT == 4'd1) begin
                    push    = 1'b1;
                    state_d = LOCKED;
                end else begin
                    state_d = COUNTING;
                end
            end else if (state_q == COUNTING) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == STABLE_CNT) begin
                    push    = 1'b1;
                    state_d = LOCKED;
                end
            end
        end
    end

    // Stabilizer FSM: outputs
    always_comb begin
        locked   = (state_q == LOCKED);
        cur_sign = cur_sign_q;
    end

    // FIFO control: a pop frees the slot a same-cycle push needs
    always_comb begin
        full        = (count_q == FULL_CNT);
        pop         = (count_q != '0) && out_ready;
        push_accept = push && (!full || pop);
        drop        = push && full && !pop;
        wr_ptr_d    = push_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({push_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_accept && !rst) begin
            mem_q[wr_ptr_q] <= candidate;
        end
    end

    always_comb begin
        out_valid  = (count_q != '0);
        out_sign   = out_valid ? mem_q[rd_ptr_q] : '0;
        fifo_count = count_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_sign_text_stabilizer.sv
// Directed bench for sign_text_stabilizer: debounce, lock, FIFO overflow/order and reset.
module tb_sign_text_stabilizer;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_end;
    logic [4:0] finger_status;
    logic       hand_present;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sign;
    logic [3:0] fifo_count;
    logic [3:0] cur_sign;
    logic       locked;
    logic       overflow;
    logic       overflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sign_text_stabilizer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_end     (frame_end),
        .finger_status (finger_status),
        .hand_present  (hand_present),
        .mode          (mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sign      (out_sign),
        .fifo_count    (fifo_count),
        .cur_sign      (cur_sign),
        .locked        (locked),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame_end strobe; returns at the falling edge after the sampling edge
    task automatic frame(input logic [4:0] fs, input logic hp, input logic md, input logic rdy);
        @(negedge clk);
        finger_status = fs;
        hand_present  = hp;
        mode          = md;
        out_ready     = rdy;
        frame_end     = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        out_ready = 1'b0;
        $display("frame fs=%b hand=%0d mode=%0d rdy=%0d -> cur=%0d locked=%0d cnt=%0d",
                 fs, hp, md, rdy, cur_sign, locked, fifo_count);
    endtask

    task automatic gesture(input logic [4:0] code);
        repeat (3) frame(code, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic pop_one(input string tag, input logic [3:0] exp);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_sign"}, out_sign, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("pop expected=%0d", exp);
    endtask

    initial begin
        rst           = 1'b1;
        frame_end     = 1'b0;
        finger_status = '0;
        hand_present  = 1'b0;
        mode          = 1'b0;
        out_ready     = 1'b0;
        overflow_clr  = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sign", out_sign, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_cur", cur_sign, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Count mode: three frames of 3 fingers
        frame(5'b00111, 1'b1, 1'b0, 1'b0);
        frame(5'b00111, 1'b1, 1'b0, 1'b0);
        check_eq("cnt_two_frames_valid", out_valid, 0);
        frame(5'b00111, 1'b1, 1'b0, 1'b0);
        check_eq("cnt_valid", out_valid, 1);
        check_eq("cnt_sign", out_sign, 3);
        check_eq("cnt_locked", locked, 1);
        check_eq("cnt_count", fifo_count, 1);
        frame(5'b00111, 1'b1, 1'b0, 1'b0);
        check_eq("cnt_hold_count", fifo_count, 1);
        pop_one("cnt_pop", 4'd3);
        check_eq("cnt_empty", fifo_count, 0);

        // Pattern mode: candidate switches 9 -> 6
        frame(5'b01001, 1'b1, 1'b1, 1'b0);
        frame(5'b01001, 1'b1, 1'b1, 1'b0);
        frame(5'b00110, 1'b1, 1'b1, 1'b0);
        frame(5'b00110, 1'b1, 1'b1, 1'b0);
        check_eq("pat_mid_count", fifo_count, 0);
        frame(5'b00110, 1'b1, 1'b1, 1'b0);
        check_eq("pat_count", fifo_count, 1);
        check_eq("pat_cur", cur_sign, 6);
        check_eq("pat_locked", locked, 1);
        pop_one("pat_pop", 4'd6);

        // No-hand frame restarts the count
        frame(5'b00011, 1'b1, 1'b0, 1'b0);
        frame(5'b00011, 1'b1, 1'b0, 1'b0);
        frame(5'b00011, 1'b0, 1'b0, 1'b0);
        check_eq("nohand_locked", locked, 0);
        check_eq("nohand_cur_held", cur_sign, 2);
        frame(5'b00011, 1'b1, 1'b0, 1'b0);
        frame(5'b00011, 1'b1, 1'b0, 1'b0);
        check_eq("nohand_count", fifo_count, 0);
        check_eq("nohand_unlocked", locked, 0);
        frame(5'b00011, 1'b1, 1'b0, 1'b0);
        check_eq("nohand_third_count", fifo_count, 1);
        pop_one("nohand_pop", 4'd2);

        // Fill, overflow, clear, drain in order
        for (int i = 1; i <= 8; i++) gesture(5'(i));
        check_eq("full_count", fifo_count, 8);
        check_eq("full_no_ovf", overflow, 0);
        gesture(5'd9);
        check_eq("drop_count", fifo_count, 8);
        check_eq("drop_ovf", overflow, 1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check_eq("ovf_clr", overflow, 0);
        for (int i = 1; i <= 8; i++) pop_one("drain", 4'(i));
        check_eq("drain_empty", fifo_count, 0);
        check_eq("drain_valid", out_valid, 0);

        // Full FIFO with push coincident with pop
        for (int i = 10; i <= 15; i++) gesture(5'(i));
        gesture(5'd1);
        gesture(5'd2);
        check_eq("full2_count", fifo_count, 8);
        frame(5'd3, 1'b1, 1'b1, 1'b0);
        frame(5'd3, 1'b1, 1'b1, 1'b0);
        frame(5'd3, 1'b1, 1'b1, 1'b1);
        check_eq("pushpop_count", fifo_count, 8);
        check_eq("pushpop_ovf", overflow, 0);
        for (int i = 11; i <= 15; i++) pop_one("pp_drain", 4'(i));
        pop_one("pp_drain", 4'd1);
        pop_one("pp_drain", 4'd2);
        pop_one("pp_last", 4'd3);
        check_eq("pp_empty", fifo_count, 0);

        // Reset mid-gesture with entries buffered
        gesture(5'd4);
        gesture(5'd5);
        gesture(5'd6);
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        check_eq("pre_rst_count", fifo_count, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_count", fifo_count, 0);
        check_eq("midrst_sign", out_sign, 0);
        check_eq("midrst_cur", cur_sign, 0);
        check_eq("midrst_locked", locked, 0);
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        check_eq("rst_frame_ignored", cur_sign, 0);
        @(negedge clk);
        rst = 1'b0;
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        check_eq("post_rst_two", fifo_count, 0);
        frame(5'd7, 1'b1, 1'b1, 1'b0);
        check_eq("post_rst_three", fifo_count, 1);
        check_eq("post_rst_sign", out_sign, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
